// File: rtl/present_sbox_layer.sv
// present_sbox_layer: PRESENT 4-bit S-box substitution over a WIDTH-bit state,
// LANES nibbles per clock, valid/ready handshake on input and output.
// Optional feature macro: SBOX_INV_EN (compiles in the inverse S-box; in_inv
// then selects forward/inverse per operation; otherwise in_inv is unused).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake for in_data/in_inv
//   in_data [WIDTH-1:0]    state to substitute (nibble i = in_data[4i+3:4i])
//   in_inv                 1 = inverse S-box, 0 = forward
//   out_valid/out_ready    output handshake for out_data
//   out_data [WIDTH-1:0]   substituted state (work register)
//   busy                   high while substitution is in progress
`timescale 1ns/1ps
module present_sbox_layer #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned LANES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int unsigned NCYC = WIDTH / (4 * LANES);
   localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   generate
      if ((WIDTH % (4 * LANES)) != 0) begin : g_bad_cfg
         $error("present_sbox_layer: WIDTH must be a multiple of 4*LANES");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_nxt;
   logic             inv_q;

   // Forward PRESENT S-box
   function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

`ifdef SBOX_INV_EN
   // Inverse PRESENT S-box
   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction
`else
   // Forward-only build: direction flag is constant, in_inv is ignored
   logic unused_inv;
   assign inv_q      = 1'b0;
   assign unused_inv = ^{in_inv, inv_q};
`endif

   // Substitute the nibble group currently selected by cnt, low group first
   always_comb begin
      work_nxt = work;
      for (int g = 0; g < int'(NCYC); g++) begin
         if (cnt == CW'(g)) begin
            for (int l = 0; l < int'(LANES); l++) begin
`ifdef SBOX_INV_EN
               work_nxt[(g*int'(LANES)+l)*4 +: 4] =
                  inv_q ? sbox_inv(work[(g*int'(LANES)+l)*4 +: 4])
                        : sbox_fwd(work[(g*int'(LANES)+l)*4 +: 4]);
`else
               work_nxt[(g*int'(LANES)+l)*4 +: 4] =
                  sbox_fwd(work[(g*int'(LANES)+l)*4 +: 4]);
`endif
            end
         end
      end
   end

   // Control FSM, work register and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         work      <= '0;
`ifdef SBOX_INV_EN
         inv_q     <= 1'b0;
`endif
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work     <= in_data;
`ifdef SBOX_INV_EN
                  inv_q    <= in_inv;
`endif
                  cnt      <= '0;
                  state    <= BUSY;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            BUSY: begin
               work <= work_nxt;
               if (cnt == CW'(NCYC - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_data = work;

endmodule

// File: tb/tb_present_sbox_layer.sv
// Testbench for present_sbox_layer: three instances (LANES = 4, 1, 16) with
// directed and random operations checked against a table-lookup model.
`timescale 1ns/1ps
module tb_present_sbox_layer;

   localparam int unsigned LN [3] = '{4, 1, 16};
   localparam int          NC [3] = '{4, 16, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_v  [3];
   logic        in_inv_v    [3];
   logic        out_ready_v [3];
   logic [63:0] in_data_v   [3];
   logic        in_ready_v  [3];
   logic        out_valid_v [3];
   logic        busy_v      [3];
   logic [63:0] out_data_v  [3];

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar k = 0; k < 3; k++) begin : g_dut
         present_sbox_layer #(.WIDTH(64), .LANES(LN[k])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[k]),
            .in_ready  (in_ready_v[k]),
            .in_data   (in_data_v[k]),
            .in_inv    (in_inv_v[k]),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready_v[k]),
            .out_data  (out_data_v[k]),
            .busy      (busy_v[k])
         );
      end
   endgenerate

   // Reference: per-nibble table lookup; inverse found by searching the forward table
   function automatic logic [63:0] ref_sub(input logic [63:0] d, input logic inv);
      logic [63:0] r;
      logic        use_inv;
`ifdef SBOX_INV_EN
      use_inv = inv;
`else
      use_inv = 1'b0 & inv;
`endif
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (use_inv) begin
            for (int j = 0; j < 16; j++)
               if (fwd_t[j] == d[4*i +: 4]) r[4*i +: 4] = 4'(j);
         end else begin
            r[4*i +: 4] = fwd_t[d[4*i +: 4]];
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One operation on instance k; stall>0 holds out_ready low that many cycles
   task automatic run_op(input int k, input logic [63:0] d, input logic inv, input int stall,
                         output logic [63:0] res, output int lat, output int bcnt, output int acc);
      int w;
      logic [63:0] held;
      w = 0;
      while (!in_ready_v[k] && w < 200) begin
         tick();
         w++;
      end
      if (!in_ready_v[k]) check("in_ready_timeout", 64'(in_ready_v[k]), 64'd1);
      out_ready_v[k] = (stall == 0);
      in_data_v[k]   = d;
      in_inv_v[k]    = inv;
      in_valid_v[k]  = 1'b1;
      tick();
      acc = cyc;
      in_valid_v[k] = 1'b0;
      in_inv_v[k]   = ~inv;
      in_data_v[k]  = {$urandom, $urandom};
      lat = 0;
      bcnt = 0;
      while (!out_valid_v[k] && lat < 200) begin
         bcnt += int'(busy_v[k]);
         tick();
         lat++;
      end
      res = out_data_v[k];
      if (stall > 0) begin
         held = res;
         for (int s = 0; s < stall; s++) begin
            in_valid_v[k] = 1'b1;
            in_data_v[k]  = ~d;
            tick();
            check("stall_out_valid", 64'(out_valid_v[k]), 64'd1);
            check("stall_out_data", out_data_v[k], held);
            check("stall_in_ready", 64'(in_ready_v[k]), 64'd0);
         end
         in_valid_v[k]  = 1'b0;
         out_ready_v[k] = 1'b1;
         tick();
         check("release_in_ready", 64'(in_ready_v[k]), 64'd1);
         check("release_out_valid", 64'(out_valid_v[k]), 64'd0);
         out_ready_v[k] = 1'b0;
      end
   endtask

   initial begin
      logic [63:0] res, d;
      int lat, bcnt, acc1, acc2, k, st;
      logic inv;

      for (int i = 0; i < 3; i++) begin
         in_valid_v[i] = 1'b0; in_inv_v[i] = 1'b0;
         out_ready_v[i] = 1'b0; in_data_v[i] = '0;
      end

      // Reset state
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         check("rst_in_ready", 64'(in_ready_v[i]), 64'd1);
         check("rst_out_valid", 64'(out_valid_v[i]), 64'd0);
         check("rst_busy", 64'(busy_v[i]), 64'd0);
         check("rst_out_data", out_data_v[i], 64'd0);
      end
      rst_n = 1'b1;
      tick();

      // T1 forward of zero
      run_op(0, 64'h0, 1'b0, 0, res, lat, bcnt, acc1);
      check("t1_data", res, 64'hCCCC_CCCC_CCCC_CCCC);
      check("t1_latency", 64'(lat), 64'd4);

      // T2 forward of counting pattern, busy duration
      run_op(0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, res, lat, bcnt, acc1);
      check("t2_data", res, 64'hC56B_90AD_3EF8_4712);
      check("t2_busy_cycles", 64'(bcnt), 64'd4);

      // T3 inverse (degenerates to forward without the inverse table)
      run_op(0, 64'hC56B_90AD_3EF8_4712, 1'b1, 0, res, lat, bcnt, acc1);
      check("t3_data", res, ref_sub(64'hC56B_90AD_3EF8_4712, 1'b1));
      run_op(0, 64'h0, 1'b1, 0, res, lat, bcnt, acc1);
      check("t3_zero_inv", res, ref_sub(64'h0, 1'b1));

      // T4 backpressure
      d = {$urandom, $urandom};
      run_op(0, d, 1'b0, 10, res, lat, bcnt, acc1);
      check("t4_data", res, ref_sub(d, 1'b0));

      // T5 reset two cycles after accept
      in_data_v[0] = 64'h0123_4567_89AB_CDEF; in_inv_v[0] = 1'b0; in_valid_v[0] = 1'b1;
      out_ready_v[0] = 1'b1;
      tick();
      in_valid_v[0] = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("t5_out_valid", 64'(out_valid_v[0]), 64'd0);
      check("t5_in_ready", 64'(in_ready_v[0]), 64'd1);
      check("t5_out_data", out_data_v[0], 64'd0);
      check("t5_busy", 64'(busy_v[0]), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op(0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, res, lat, bcnt, acc1);
      check("t5_fresh_data", res, 64'hC56B_90AD_3EF8_4712);

      // T6 other lane counts: latency and back-to-back throughput
      for (int i = 1; i < 3; i++) begin
         run_op(i, 64'h0123_4567_89AB_CDEF, 1'b0, 0, res, lat, bcnt, acc1);
         check("t6_data", res, 64'hC56B_90AD_3EF8_4712);
         check("t6_latency", 64'(lat), 64'(NC[i]));
         run_op(i, 64'hFEDC_BA98_7654_3210, 1'b0, 0, res, lat, bcnt, acc2);
         check("t6_data2", res, ref_sub(64'hFEDC_BA98_7654_3210, 1'b0));
         check("t6_throughput", 64'(acc2 - acc1), 64'(NC[i] + 2));
      end
      run_op(0, 64'h1111_2222_3333_4444, 1'b0, 0, res, lat, bcnt, acc1);
      run_op(0, 64'h5555_6666_7777_8888, 1'b0, 0, res, lat, bcnt, acc2);
      check("t6_throughput_l4", 64'(acc2 - acc1), 64'd6);

      // Random operations over all instances
      for (int n = 0; n < 30; n++) begin
         k   = int'($urandom_range(0, 2));
         d   = {$urandom, $urandom};
         inv = 1'($urandom);
         st  = int'($urandom_range(0, 3));
         run_op(k, d, inv, st, res, lat, bcnt, acc1);
         check("rand_data", res, ref_sub(d, inv));
         check("rand_latency", 64'(lat), 64'(NC[k]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
